painterengine_gpu_dvi_fetch: RTL and testbench

PAINTERENGINE_GPU_DVI_FETCH -- requirements
Module: painterengine_gpu_dvi_fetch

---
 rtl/painterengine_gpu_pkg.sv | 16 +
 rtl/painterengine_gpu_sync_fifo.sv | 54 +++++
 rtl/painterengine_gpu_dvi_fetch.sv | 113 +++++++++++
 tb/tb_painterengine_gpu_dvi_fetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared constants for the painterengine GPU blocks: fetch FSM encodings,
// the read-address stride and the frame-size helper.
package painterengine_gpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] ADDR_STRIDE = 32'd4;

  function automatic logic [31:0] frame_total(input logic [15:0] width, input logic [15:0] height);
    return 32'(width) * 32'(height);
  endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock FIFO with combinational head; pointers wrap naturally because
// the depth is a power of two.
module painterengine_gpu_sync_fifo #(
  parameter int PARAM_WIDTH = 32,
  parameter int PARAM_DEPTH = 16
) (
  input  logic                         i_wire_pixel_clock,
  input  logic                         i_wire_resetn,
  input  logic                         i_wire_push,
  input  logic [PARAM_WIDTH-1:0]       i_wire_push_data,
  input  logic                         i_wire_pop,
  output logic [PARAM_WIDTH-1:0]       o_wire_head,
  output logic [$clog2(PARAM_DEPTH):0] o_wire_count,
  output logic                         o_wire_full,
  output logic                         o_wire_empty
);

  localparam int AW = $clog2(PARAM_DEPTH);

  logic [PARAM_WIDTH-1:0] mem [PARAM_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   do_push;
  logic                   do_pop;

  assign o_wire_full  = (count == (AW+1)'(PARAM_DEPTH));
  assign o_wire_empty = (count == '0);
  assign o_wire_count = count;
  assign o_wire_head  = mem[rd_ptr];
  assign do_push      = i_wire_push && !o_wire_full;
  assign do_pop       = i_wire_pop && !o_wire_empty;

  always_ff @(posedge i_wire_pixel_clock) begin
    if (do_push) mem[wr_ptr] <= i_wire_push_data;
  end

  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/painterengine_gpu_dvi_fetch.sv
// Frame fetcher: streams clip_width*clip_height words from memory into a
// pixel FIFO that the DVI timing stage drains one pixel per next_rgb.
//
// state    | meaning
// IDLE     | waiting for the first start after reset
// FETCH    | issuing reads, throttled by fifo_count + outstanding
// DRAIN    | all reads accepted, waiting for the last pixel to be popped
// DONE     | frame complete; done held until the next accepted start
module painterengine_gpu_dvi_fetch
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_DATA_WIDTH = 32,
  parameter int PARAM_FIFO_DEPTH = 16
) (
  input  logic                        i_wire_pixel_clock,
  input  logic                        i_wire_resetn,
  input  logic                        i_wire_start,
  input  logic [31:0]                 i_wire_frame_base,
  input  logic [15:0]                 i_wire_clip_width,
  input  logic [15:0]                 i_wire_clip_height,
  output logic                        o_wire_mem_req,
  output logic [31:0]                 o_wire_mem_addr,
  input  logic                        i_wire_mem_ack,
  input  logic                        i_wire_mem_rvalid,
  input  logic [PARAM_DATA_WIDTH-1:0] i_wire_mem_rdata,
  input  logic                        i_wire_next_rgb,
  output logic [PARAM_DATA_WIDTH-1:0] o_wire_rgba,
  output logic                        o_wire_rgba_valid,
  output logic                        o_wire_busy,
  output logic                        o_wire_done,
  output logic                        o_wire_underflow
);

  localparam int CW = $clog2(PARAM_FIFO_DEPTH) + 1;

  logic [1:0]                  state;
  logic [31:0]                 total;
  logic [31:0]                 req_cnt;
  logic [31:0]                 pop_cnt;
  logic [CW-1:0]               outstanding;
  logic [CW-1:0]               fifo_count;
  logic [PARAM_DATA_WIDTH-1:0] fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        start_ok;
  logic                        accept;
  logic                        fifo_pop;
  logic [31:0]                 new_total;

  assign new_total   = frame_total(i_wire_clip_width, i_wire_clip_height);
  assign o_wire_busy = (state == ST_FETCH) || (state == ST_DRAIN);
  assign o_wire_done = (state == ST_DONE);
  assign start_ok    = i_wire_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign fifo_pop    = i_wire_next_rgb && o_wire_busy && !fifo_empty;

  // Credit check counts reads already in flight so a return never meets a full FIFO.
  assign o_wire_mem_req = (state == ST_FETCH) && !fifo_full &&
                          (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(PARAM_FIFO_DEPTH));
  assign accept         = o_wire_mem_req && i_wire_mem_ack;

  assign o_wire_rgba_valid = !fifo_empty;
  assign o_wire_rgba       = fifo_empty ? '0 : fifo_head;

  painterengine_gpu_sync_fifo #(
    .PARAM_WIDTH (PARAM_DATA_WIDTH),
    .PARAM_DEPTH (PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_pixel_clock (i_wire_pixel_clock),
    .i_wire_resetn      (i_wire_resetn),
    .i_wire_push        (i_wire_mem_rvalid),
    .i_wire_push_data   (i_wire_mem_rdata),
    .i_wire_pop         (fifo_pop),
    .o_wire_head        (fifo_head),
    .o_wire_count       (fifo_count),
    .o_wire_full        (fifo_full),
    .o_wire_empty       (fifo_empty)
  );

  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state            <= ST_IDLE;
      total            <= '0;
      req_cnt          <= '0;
      pop_cnt          <= '0;
      outstanding      <= '0;
      o_wire_mem_addr  <= '0;
      o_wire_underflow <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(i_wire_mem_rvalid);
      if (start_ok) begin
        total            <= new_total;
        o_wire_mem_addr  <= i_wire_frame_base;
        req_cnt          <= '0;
        pop_cnt          <= '0;
        o_wire_underflow <= 1'b0;
        state            <= (new_total == '0) ? ST_DONE : ST_FETCH;
      end else begin
        if (accept) begin
          o_wire_mem_addr <= o_wire_mem_addr + ADDR_STRIDE;
          req_cnt         <= req_cnt + 32'd1;
        end
        if (fifo_pop) pop_cnt <= pop_cnt + 32'd1;
        if (i_wire_next_rgb && o_wire_busy && fifo_empty) o_wire_underflow <= 1'b1;
        case (state)
          ST_FETCH: if (accept && (req_cnt + 32'd1 == total)) state <= ST_DRAIN;
          ST_DRAIN: if (fifo_pop && (pop_cnt + 32'd1 == total)) state <= ST_DONE;
          default:  state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dvi_fetch.sv
// Directed bench for the DVI frame fetcher with an address/pixel scoreboard
// and a fixed-latency memory model.
module tb_painterengine_gpu_dvi_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] frame_base;
  logic [15:0] clip_w;
  logic [15:0] clip_h;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        next_rgb;
  logic [31:0] rgba;
  logic        rgba_valid;
  logic        busy;
  logic        done;
  logic        underflow;

  always #5 clk = ~clk;

  painterengine_gpu_dvi_fetch #(
    .PARAM_DATA_WIDTH (32),
    .PARAM_FIFO_DEPTH (16)
  ) dut (
    .i_wire_pixel_clock (clk),
    .i_wire_resetn      (rstn),
    .i_wire_start       (start),
    .i_wire_frame_base  (frame_base),
    .i_wire_clip_width  (clip_w),
    .i_wire_clip_height (clip_h),
    .o_wire_mem_req     (mem_req),
    .o_wire_mem_addr    (mem_addr),
    .i_wire_mem_ack     (mem_ack),
    .i_wire_mem_rvalid  (mem_rvalid),
    .i_wire_mem_rdata   (mem_rdata),
    .i_wire_next_rgb    (next_rgb),
    .o_wire_rgba        (rgba),
    .o_wire_rgba_valid  (rgba_valid),
    .o_wire_busy        (busy),
    .o_wire_done        (done),
    .o_wire_underflow   (underflow)
  );

  int total_n = 0;
  int bad_n   = 0;

  logic [31:0] addr_q[$];
  logic [31:0] pix_q[$];
  logic [31:0] ret_data_q[$];
  int          ret_due_q[$];
  int          ncyc = 0;
  int          acc_cnt = 0;
  int          ret_cnt = 0;
  int          pop_cnt_tb = 0;
  int          ret_lat = 1;
  bit          ack_en = 1'b0;
  bit          pop_en = 1'b0;
  bit          force_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory and consumer model: inputs change on the falling edge only.
  always @(negedge clk) begin
    ncyc++;
    if (!rstn) begin
      ret_data_q.delete();
      ret_due_q.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      next_rgb   = 1'b0;
    end else begin
      if (ret_due_q.size() > 0 && ret_due_q[0] <= ncyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ret_data_q.pop_front();
        void'(ret_due_q.pop_front());
        ret_cnt++;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      mem_ack = ack_en;
      if (mem_req && ack_en) begin
        acc_cnt++;
        if (addr_q.size() == 0) check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
        else check("req_addr", mem_addr, addr_q.pop_front());
        ret_data_q.push_back(pix_of(mem_addr));
        ret_due_q.push_back(ncyc + ret_lat);
      end
      next_rgb = force_next | (pop_en & rgba_valid);
      if (pop_en && rgba_valid) begin
        pop_cnt_tb++;
        if (pix_q.size() == 0) check("unexpected_pix", rgba, 32'hFFFF_FFFF);
        else check("pixel", rgba, pix_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_frame(input logic [31:0] base, input int w, input int h);
    for (int i = 0; i < w * h; i++) begin
      addr_q.push_back(base + 32'(4 * i));
      pix_q.push_back(pix_of(base + 32'(4 * i)));
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h);
    frame_base = base;
    clip_w     = w;
    clip_h     = h;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int c = 0;
    while (!done && c < limit) begin
      step();
      c++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'd0);
    check({tag, "_mem_addr"},   mem_addr,        32'd0);
    check({tag, "_rgba"},       rgba,            32'd0);
    check({tag, "_rgba_valid"}, 32'(rgba_valid), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_underflow"},  32'(underflow),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    frame_base = '0;
    clip_w     = '0;
    clip_h     = '0;
    #7;
    check_reset_outputs("reset");
    step(2);
    rstn = 1'b1;
    step(2);

    // Zero-width frame completes immediately without touching memory.
    ack_en = 1'b1;
    check("zero_done_before", 32'(done), 32'd0);
    pulse_start(32'h100, 16'd0, 16'd5);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("zero_no_req", 32'(mem_req), 32'd0);
      check("zero_busy_hold", 32'(busy), 32'd0);
      step();
    end
    check("zero_acc", 32'(acc_cnt), 32'd0);

    // 4x2 frame, ack always, one-cycle return, consumer pops whenever valid.
    pop_en  = 1'b1;
    ret_lat = 1;
    acc_cnt = 0;
    expect_frame(32'h1000, 4, 2);
    pulse_start(32'h1000, 16'd4, 16'd2);
    check("f1_busy", 32'(busy), 32'd1);
    wait_done("f1_done", 100);
    check("f1_addr_left", 32'(addr_q.size()), 32'd0);
    check("f1_pix_left", 32'(pix_q.size()), 32'd0);
    check("f1_acc", 32'(acc_cnt), 32'd8);
    check("f1_underflow", 32'(underflow), 32'd0);
    check("f1_busy_end", 32'(busy), 32'd0);

    // 64-pixel frame with no consumer: credit limit stops requests at 16.
    pop_en  = 1'b0;
    acc_cnt = 0;
    expect_frame(32'h2000, 8, 8);
    pulse_start(32'h2000, 16'd8, 16'd8);
    step(40);
    check("bp_acc16", 32'(acc_cnt), 32'd16);
    check("bp_req_off", 32'(mem_req), 32'd0);
    check("bp_valid", 32'(rgba_valid), 32'd1);
    check("bp_head", rgba, pix_of(32'h2000));
    pop_en = 1'b1;
    step();
    pop_en = 1'b0;
    step(3);
    check("bp_resume", 32'(acc_cnt), 32'd17);
    check("bp_head2", rgba, pix_of(32'h2004));
    pop_en = 1'b1;
    wait_done("bp_done", 400);
    check("bp_addr_left", 32'(addr_q.size()), 32'd0);
    check("bp_pix_left", 32'(pix_q.size()), 32'd0);

    // Pop strobe with the FIFO empty sets sticky underflow without popping.
    ack_en  = 1'b0;
    pop_en  = 1'b0;
    acc_cnt = 0;
    expect_frame(32'h3000, 2, 2);
    pulse_start(32'h3000, 16'd2, 16'd2);
    check("uf_clear_on_start", 32'(underflow), 32'd0);
    force_next = 1'b1;
    step();
    force_next = 1'b0;
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_rgba", rgba, 32'd0);
    check("uf_valid", 32'(rgba_valid), 32'd0);
    step(3);
    check("uf_sticky", 32'(underflow), 32'd1);
    ack_en = 1'b1;
    pop_en = 1'b1;
    wait_done("uf_done", 100);
    check("uf_pix_left", 32'(pix_q.size()), 32'd0);
    check("uf_sticky_done", 32'(underflow), 32'd1);

    // Start during FETCH with other dimensions is ignored.
    acc_cnt = 0;
    expect_frame(32'h4000, 4, 2);
    pulse_start(32'h4000, 16'd4, 16'd2);
    check("ig_uf_cleared", 32'(underflow), 32'd0);
    check("ig_busy", 32'(busy), 32'd1);
    step(2);
    pulse_start(32'h8000, 16'd16, 16'd16);
    check("ig_still_busy", 32'(busy), 32'd1);
    wait_done("ig_done", 100);
    check("ig_acc", 32'(acc_cnt), 32'd8);
    check("ig_addr_left", 32'(addr_q.size()), 32'd0);
    check("ig_pix_left", 32'(pix_q.size()), 32'd0);
    step(5);
    check("ig_done_hold", 32'(done), 32'd1);

    // Reset after 5 of 8 pixels popped with 2 reads still in flight.
    ret_lat    = 3;
    acc_cnt    = 0;
    ret_cnt    = 0;
    pop_cnt_tb = 0;
    expect_frame(32'h5000, 4, 2);
    pulse_start(32'h5000, 16'd4, 16'd2);
    begin
      int c = 0;
      while (pop_cnt_tb < 5 && c < 100) begin
        @(negedge clk);
        #1;
        c++;
      end
    end
    check("rst_pops5", 32'(pop_cnt_tb), 32'd5);
    @(posedge clk);
    #2;
    pop_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check("rst_outstanding", 32'(acc_cnt - ret_cnt), 32'd2);
    check_reset_outputs("rst_mid");
    addr_q.delete();
    pix_q.delete();
    step(2);
    rstn = 1'b1;
    step();
    ret_lat = 1;
    pop_en  = 1'b1;
    acc_cnt = 0;
    expect_frame(32'h5000, 4, 2);
    pulse_start(32'h5000, 16'd4, 16'd2);
    wait_done("rst_refetch_done", 100);
    check("rst_acc", 32'(acc_cnt), 32'd8);
    check("rst_addr_left", 32'(addr_q.size()), 32'd0);
    check("rst_pix_left", 32'(pix_q.size()), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
